// File: rtl/rns_exec_pipe_pkg.sv
// Shared definitions for the RNS execution pipeline.
//   RNS_NUM_DOMAINS / RNS_DATA_WID : default channel count and residue width
//   RNS_MODULI                     : default packed moduli, field d = modulus of domain d
//   rns_op_e                       : operation encodings carried on in_op
package rns_exec_pipe_pkg;

    localparam int unsigned RNS_NUM_DOMAINS = 2;
    localparam int unsigned RNS_DATA_WID    = 8;

    // Domain 1 = 129, domain 0 = 256 (lowest field is domain 0).
    localparam logic [RNS_NUM_DOMAINS*(RNS_DATA_WID+1)-1:0] RNS_MODULI = {9'd129, 9'd256};

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } rns_op_e;

endpackage

// File: rtl/rns_exec_pipe_mod_reduce.sv
// rns_mod_reduce: reduces a 2*DATA_WID-bit value modulo a constant MODULUS.
//   i_val : value to reduce
//   o_res : i_val mod MODULUS, always < MODULUS
// A modulus of exactly 2^DATA_WID is handled by truncation, so no divider
// is built for such domains.
module rns_mod_reduce #(
    parameter int unsigned DATA_WID = 8,
    parameter int unsigned MODULUS  = 256
) (
    input  logic [2*DATA_WID-1:0] i_val,
    output logic [DATA_WID-1:0]   o_res
);

    localparam int unsigned W = DATA_WID;

    generate
        if (MODULUS == (32'd1 << W)) begin : g_trunc
            logic w_unused_hi;
            assign w_unused_hi = ^i_val[2*W-1:W];
            assign o_res       = i_val[W-1:0];
        end else begin : g_div
            localparam logic [2*W-1:0] M_EXT = (2*W)'(MODULUS);
            logic [2*W-1:0] w_rem;
            logic           w_unused_hi;
            assign w_rem       = i_val % M_EXT;
            // Remainder is below MODULUS < 2^W, so the upper half is always zero.
            assign w_unused_hi = ^w_rem[2*W-1:W];
            assign o_res       = w_rem[W-1:0];
        end
    endgenerate

endmodule

// File: rtl/rns_exec_pipe.sv
// rns_exec_pipe: three-stage residue-number-system ALU pipeline.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : operation handshake; in_op, in_a, in_b, in_tag payload
//   flush                 : synchronous kill of every in-flight operation
//   out_valid/out_ready   : result handshake; out_res, out_tag, out_err payload
//   occupancy             : number of valid stages (0..3)
// S1 holds operands, S2 the unreduced per-domain result, S3 the reduced result.
module rns_exec_pipe
    import rns_exec_pipe_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = RNS_NUM_DOMAINS,
    parameter int unsigned DATA_WID    = RNS_DATA_WID,
    parameter logic [NUM_DOMAINS*(DATA_WID+1)-1:0] MODULI = RNS_MODULI,
    parameter int unsigned TAG_WID     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_op,
    input  logic [NUM_DOMAINS*DATA_WID-1:0] in_a,
    input  logic [NUM_DOMAINS*DATA_WID-1:0] in_b,
    input  logic [TAG_WID-1:0]              in_tag,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_DOMAINS*DATA_WID-1:0] out_res,
    output logic [TAG_WID-1:0]              out_tag,
    output logic [NUM_DOMAINS-1:0]          out_err,
    output logic [1:0]                      occupancy
);

    localparam int unsigned W  = DATA_WID;
    localparam int unsigned N  = NUM_DOMAINS;
    localparam int unsigned MW = DATA_WID + 1;

    // Stage 1
    logic               r_s1_valid;
    rns_op_e            r_s1_op;
    logic [N*W-1:0]     r_s1_a;
    logic [N*W-1:0]     r_s1_b;
    logic [TAG_WID-1:0] r_s1_tag;

    // Stage 2
    logic               r_s2_valid;
    logic [N*2*W-1:0]   r_s2_raw;
    logic [N-1:0]       r_s2_err;
    logic [TAG_WID-1:0] r_s2_tag;

    // Stage 3
    logic               r_s3_valid;
    logic [N*W-1:0]     r_s3_res;
    logic [N-1:0]       r_s3_err;
    logic [TAG_WID-1:0] r_s3_tag;

    logic               w_adv;
    logic [N*2*W-1:0]   w_raw;
    logic [N-1:0]       w_err;
    logic [N*W-1:0]     w_red;

    assign w_adv     = !r_s3_valid || out_ready;
    assign in_ready  = w_adv && !flush;

    assign out_valid = r_s3_valid;
    assign out_res   = r_s3_res;
    assign out_tag   = r_s3_tag;
    assign out_err   = r_s3_err;
    assign occupancy = {1'b0, r_s1_valid} + {1'b0, r_s2_valid} + {1'b0, r_s3_valid};

    generate
        for (genvar d = 0; d < N; d++) begin : g_dom
            localparam logic [MW-1:0]  M_D = MODULI[d*MW +: MW];
            localparam logic [2*W-1:0] M_X = (2*W)'(M_D);

            logic [W-1:0]   w_a;
            logic [W-1:0]   w_b;
            logic [W-1:0]   w_ar;
            logic [W-1:0]   w_br;
            logic [2*W-1:0] w_ax;
            logic [2*W-1:0] w_bx;
            logic [2*W-1:0] w_res;

            assign w_a = r_s1_a[d*W +: W];
            assign w_b = r_s1_b[d*W +: W];

            // Operands are canonicalised first so that every raw result
            // fits in 2*W bits and one reduction finishes the job.
            if (M_D == {1'b1, {W{1'b0}}}) begin : g_pow2
                assign w_ar = w_a;
                assign w_br = w_b;
            end else begin : g_gen
                localparam logic [W-1:0] M_W = M_D[W-1:0];
                assign w_ar = w_a % M_W;
                assign w_br = w_b % M_W;
            end

            assign w_err[d] = ({1'b0, w_a} >= M_D) || ({1'b0, w_b} >= M_D);
            assign w_ax     = {{W{1'b0}}, w_ar};
            assign w_bx     = {{W{1'b0}}, w_br};

            always_comb begin
                w_res = w_ax;
                case (r_s1_op)
                    OP_ADD:  w_res = w_ax + w_bx;
                    OP_SUB:  w_res = w_ax + M_X - w_bx;
                    OP_MUL:  w_res = w_ax * w_bx;
                    default: w_res = w_ax;
                endcase
            end

            assign w_raw[d*2*W +: 2*W] = w_res;

            rns_mod_reduce #(
                .DATA_WID (W),
                .MODULUS  (32'(M_D))
            ) u_reduce (
                .i_val (r_s2_raw[d*2*W +: 2*W]),
                .o_res (w_red[d*W +: W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_raw   <= '0;
            r_s2_err   <= '0;
            r_s2_tag   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_res   <= '0;
            r_s3_err   <= '0;
            r_s3_tag   <= '0;
        end else begin
            if (w_adv) begin
                r_s1_op  <= rns_op_e'(in_op);
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_tag <= in_tag;
                r_s2_raw <= w_raw;
                r_s2_err <= w_err;
                r_s2_tag <= r_s1_tag;
                r_s3_res <= w_red;
                r_s3_err <= r_s2_err;
                r_s3_tag <= r_s2_tag;
            end
            // Flush overrides a stalled output: valids drop even when adv=0.
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
                r_s3_valid <= 1'b0;
            end else if (w_adv) begin
                r_s1_valid <= in_valid;
                r_s2_valid <= r_s1_valid;
                r_s3_valid <= r_s2_valid;
            end
        end
    end

endmodule

// File: tb/tb_rns_exec_pipe.sv
// Scoreboard bench for rns_exec_pipe with MODULI = {129, 256}
// (domain 1 = 129, domain 0 = 256). Results are written {d1, d0}.
module tb_rns_exec_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [3:0]  out_tag;
    logic [1:0]  out_err;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [1:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rns_exec_pipe #(
        .NUM_DOMAINS (2),
        .DATA_WID    (8),
        .MODULI      ({9'd129, 9'd256}),
        .TAG_WID     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every output handshake, and checks that
    // a stalled result stays put.
    logic        stall_prev = 1'b0;
    logic [15:0] hold_res;
    logic [3:0]  hold_tag;
    logic [1:0]  hold_err;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                check("hold_res", out_res, hold_res);
                check("hold_tag", out_tag, hold_tag);
                check("hold_err", out_err, hold_err);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: tag %0d res %0h with nothing expected", out_tag, out_res);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_tag", out_tag, e.tag);
                    check("out_res", out_res, e.res);
                    check("out_err", out_err, e.err);
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_res   = out_res;
            hold_tag   = out_tag;
            hold_err   = out_err;
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] res, input logic [1:0] err);
        int unsigned waited = 0;
        bit          done   = 1'b0;
        exp_t        e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = res;
                e.tag = tag;
                e.err = err;
                sb_q.push_back(e);
                done = 1'b1;
            end else if (waited > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: tag %0d never accepted", tag);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Raw offer for operations that must never come out (no scoreboard entry).
    task automatic offer_raw(input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_tag   = tag;
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        @(negedge clk);
        check({name, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_lat2"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_lat3"}, out_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_res",   out_res,   16'd0);
        check("rst_out_tag",   out_tag,   4'd0);
        check("rst_out_err",   out_err,   2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready",  in_ready,  1'b1);
        check("idle_occupancy", occupancy, 2'd0);
        @(posedge clk);
        #1;

        // Basic operations: {100,200}+{100,100} -> {71,44}
        send(2'b00, 16'h64C8, 16'h6464, 4'd1, 16'h472C, 2'b00);
        check_latency("add");
        send(2'b01, 16'h0505, 16'h0A0A, 4'd2, 16'h7CFB, 2'b00);  // {124,251}
        send(2'b10, 16'h8080, 16'h8080, 4'd3, 16'h0100, 2'b00);  // {1,0}
        send(2'b11, 16'h8207, 16'h0000, 4'd4, 16'h0107, 2'b10);  // {1,7}
        send(2'b01, 16'h8101, 16'h0002, 4'd5, 16'h00FF, 2'b10);  // {0,255}
        send(2'b11, 16'h80FF, 16'h0000, 4'd6, 16'h80FF, 2'b00);  // {128,255}
        wait_drain();

        // Back-to-back with output stall: out_ready low for edges P3..P6.
        @(posedge clk);
        #1;
        fork
            begin
                send(2'b00, 16'h80FF, 16'h0101, 4'd7,  16'h0000, 2'b00);  // {0,0}
                send(2'b01, 16'h0000, 16'h80FF, 4'd8,  16'h0101, 2'b00);  // {1,1}
                send(2'b10, 16'h0210, 16'h4110, 4'd9,  16'h0100, 2'b00);  // {1,0}
                send(2'b00, 16'hC803, 16'hFF04, 4'd10, 16'h4407, 2'b10);  // {68,7}
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_occupancy", occupancy, 2'd3);
                check("stall_in_ready",  in_ready,  1'b0);
                check("stall_out_valid", out_valid, 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush with three in flight and a concurrent offer.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer_raw(4'd11);
        offer_raw(4'd12);
        offer_raw(4'd13);
        in_valid = 1'b0;
        @(negedge clk);
        check("preflush_occupancy", occupancy, 2'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_tag   = 4'd14;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_occupancy", occupancy, 2'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(2'b10, 16'h8080, 16'h8080, 4'd15, 16'h0100, 2'b00);
        wait_drain();

        // Asynchronous reset mid-cycle with a stalled, full pipeline.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer_raw(4'd1);
        offer_raw(4'd2);
        offer_raw(4'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("prereset_out_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_occupancy", occupancy, 2'd0);
        check("areset_out_res",   out_res,   16'd0);
        check("areset_out_tag",   out_tag,   4'd0);
        check("areset_out_err",   out_err,   2'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send(2'b00, 16'h64C8, 16'h6464, 4'd6, 16'h472C, 2'b00);
        check_latency("postreset");
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rns_exec_pipe.md
RNS_EXEC_PIPE -- requirements
Module: rns_exec_pipe

Interface
REQ-001 Parameter NUM_DOMAINS, default 2: number of RNS residue channels (1..4).
REQ-002 Parameter DATA_WID, default 8: residue width per domain.
REQ-003 Parameter MODULI, default {9'd129, 9'd256}: NUM_DOMAINS*(DATA_WID+1) bits; field d = bits [d*(DATA_WID+1) +: DATA_WID+1] is the modulus of domain d; each modulus in 2..2^DATA_WID.
REQ-004 Parameter TAG_WID, default 4: width of the destination-register tag carried alongside each operation.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  operation offered.
REQ-008 in_ready  out  1  operation accepted when in_valid && in_ready at a clk edge.
REQ-009 in_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 PASS.
REQ-010 in_a, in_b  in  NUM_DOMAINS*DATA_WID  operands; domain d at [d*DATA_WID +: DATA_WID].
REQ-011 in_tag  in  TAG_WID  destination tag.
REQ-012 flush  in  1  synchronous kill of all in-flight operations (branch taken).
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_res  out  NUM_DOMAINS*DATA_WID  per-domain result, same packing as in_a.
REQ-016 out_tag  out  TAG_WID  tag of the result.
REQ-017 out_err  out  NUM_DOMAINS  bit d set if either operand of domain d was >= modulus d.
REQ-018 occupancy  out  2  number of valid stages, 0..3.

Function
REQ-019 Three stages: S1 registers operands/op/tag; S2 registers raw per-domain result (2*DATA_WID bits); S3 registers result reduced mod m_d, which drives out_*.
REQ-020 Latency from acceptance to out_valid SHALL be exactly 3 cycles when out_ready is held high.
REQ-021 adv = !out_valid || out_ready; all stages advance together when adv=1 and hold otherwise.
REQ-022 in_ready = adv && !flush.
REQ-023 Per domain d: ADD = (a mod m + b mod m) mod m; SUB = (a mod m + m - b mod m) mod m; MUL = ((a mod m)*(b mod m)) mod m; PASS = a mod m.
REQ-024 All results SHALL satisfy 0 <= res < m_d; non-canonical inputs are still reduced correctly and flagged in out_err.
REQ-025 Domains with m_d = 2^DATA_WID SHALL reduce by truncation (no divider inferred).
REQ-026 flush=1 at an edge clears valid of S1, S2, S3 regardless of out_ready; the input offered that cycle is not accepted.
REQ-027 With no flush, one operation per cycle sustained throughput; no operation is lost or duplicated under any out_ready pattern.
REQ-028 out_res/out_tag/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 occupancy = popcount of S1/S2/S3 valid bits, registered-state derived (combinational from valids).

Reset
REQ-030 reset=1 asynchronously clears all stage valid bits; out_valid=0, occupancy=0, out_res=0, out_tag=0, out_err=0.
REQ-031 in_ready SHALL be 1 while reset is deasserted and pipeline empty; in-flight operations at reset assertion are discarded.

Structure
REQ-032 Op encodings, DATA_WID default and default MODULI belong in the shared RNS package.
REQ-033 One sub-module rns_mod_reduce (per-domain reduction of a 2*DATA_WID value by constant modulus) instantiated NUM_DOMAINS times via generate.

Verification (MODULI={129,256}: domain1=129, domain0=256)
REQ-034 ADD a={100,200}, b={100,100}, out_ready=1 -> after 3 cycles out_res={71,44}, out_err=0.
REQ-035 SUB a={5,5}, b={10,10} -> out_res={124,251}.
REQ-036 MUL a={128,128}, b={128,128} -> out_res={1,0}; PASS a={130,7} -> out_res={1,7}, out_err=2'b10.
REQ-037 4 back-to-back ops, out_ready low cycles 2..5 -> in_ready low, occupancy=3, results emerge in order with tags intact, none dropped.
REQ-038 flush with 3 ops in flight and in_valid=1 -> next cycle out_valid=0, occupancy=0, flushed and concurrent ops never appear.
REQ-039 reset asserted mid-stream between clk edges -> outputs clear immediately; first post-reset op emerges with 3-cycle latency.
